// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: parametrised fully-associative, write-through,
// no-write-allocate cache controller with a req/ack backing-memory port.
// Optional macro ASSOC_CACHE_PERF_CNT_EN adds saturating 16-bit hit/miss counters.
module assoc_cache_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LINES  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ASSOC_CACHE_PERF_CNT_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_RD,
    WR_THRU,
    RESP
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0]  valid;
  logic [ADDR_W-1:0] tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic [IDX_W-1:0]  ptr;

  logic              cap_wr;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              pend_hit;

  logic              lookup_hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              any_invalid;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  victim;

  // Tag match against all valid lines; scanning downward lets the lowest index win.
  always_comb begin
    lookup_hit = 1'b0;
    hit_idx    = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (valid[i] && (tag_mem[i] == cap_addr)) begin
        lookup_hit = 1'b1;
        hit_idx    = IDX_W'(i);
      end
    end
  end

  // Victim is the lowest invalid line, falling back to the round-robin pointer.
  always_comb begin
    any_invalid = 1'b0;
    free_idx    = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        any_invalid = 1'b1;
        free_idx    = IDX_W'(i);
      end
    end
    victim = any_invalid ? free_idx : ptr;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the handshake outputs, all derived from the current state.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = !flush;
        if (!flush && req_valid) begin
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cap_wr) begin
          state_next = WR_THRU;
        end else if (lookup_hit) begin
          state_next = RESP;
        end else begin
          state_next = MISS_RD;
        end
      end
      MISS_RD: begin
        mem_req  = 1'b1;
        mem_addr = cap_addr;
        if (mem_ack) begin
          state_next = RESP;
        end
      end
      WR_THRU: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = cap_addr;
        mem_wdata = cap_wdata;
        if (mem_ack) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control datapath: valid bits, replacement pointer, captured request and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid      <= '0;
      ptr        <= '0;
      cap_wr     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      pend_hit   <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (req_valid) begin
            cap_wr    <= req_wr;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
          end
        end
        LOOKUP: begin
          if (cap_wr) begin
            pend_hit <= lookup_hit;
          end else if (lookup_hit) begin
            resp_rdata <= data_mem[hit_idx];
            resp_hit   <= 1'b1;
          end
        end
        MISS_RD: begin
          if (mem_ack) begin
            valid[victim] <= 1'b1;
            if (!any_invalid) begin
              ptr <= ptr + IDX_W'(1);
            end
            resp_rdata <= mem_rdata;
            resp_hit   <= 1'b0;
          end
        end
        WR_THRU: begin
          if (mem_ack) begin
            resp_rdata <= '0;
            resp_hit   <= pend_hit;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag and data storage; never reset, only valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if ((state == LOOKUP) && cap_wr && lookup_hit) begin
        data_mem[hit_idx] <= cap_wdata;
      end else if ((state == MISS_RD) && mem_ack) begin
        tag_mem[victim]  <= cap_addr;
        data_mem[victim] <= mem_rdata;
      end
    end
  end

`ifdef ASSOC_CACHE_PERF_CNT_EN
  // Saturating hit/miss counters bumped on each LOOKUP cycle; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt != 16'hFFFF) begin
          hit_cnt <= hit_cnt + 16'd1;
        end
      end else begin
        if (miss_cnt != 16'hFFFF) begin
          miss_cnt <= miss_cnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb_assoc_cache_ctrl: directed scoreboard bench for assoc_cache_ctrl (LINES=4).
// A memory model answers mem_req after a programmable number of cycles.
module tb_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_hit;
  logic        mem_req;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef ASSOC_CACHE_PERF_CNT_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  assoc_cache_ctrl #(.ADDR_W(8), .DATA_W(32), .LINES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_hit   (resp_hit),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef ASSOC_CACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    int          accept_cyc;
    int          lat;
  } resp_exp_t;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } mem_exp_t;

  resp_exp_t resp_q[$];
  mem_exp_t  mem_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mcount   = 0;
  int ack_after_cfg = 1;
  logic [31:0] mem_data_cfg = '0;

  always #5 clk = ~clk;

  // Free-running edge counter used to measure response latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic recordFail(input string name);
    n_checks++;
    $display("[TB] FAIL %s: got event, expected none", name);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  resp_exp_t mon_e;
  always @(negedge clk) begin
    if (resp_valid) begin
      if (resp_q.size() == 0) begin
        recordFail("unexpected_resp");
      end else begin
        mon_e = resp_q.pop_front();
        checkOutput("resp_rdata", resp_rdata, mon_e.rdata);
        checkOutput("resp_hit", {31'd0, resp_hit}, {31'd0, mon_e.hit});
        checkOutput("resp_latency", cyc, mon_e.accept_cyc + mon_e.lat - 1);
      end
    end
  end

  // Memory model: checks each request cycle and acks on the programmed cycle.
  mem_exp_t mm_e;
  always @(negedge clk) begin
    if (mem_req) begin
      mcount++;
      if (mem_q.size() == 0) begin
        recordFail("unexpected_mem_req");
      end else begin
        mm_e = mem_q[0];
        checkOutput("mem_wr", {31'd0, mem_wr}, {31'd0, mm_e.wr});
        checkOutput("mem_addr", {24'd0, mem_addr}, {24'd0, mm_e.addr});
        if (mm_e.wr) checkOutput("mem_wdata", mem_wdata, mm_e.wdata);
      end
      if (mcount == ack_after_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_data_cfg;
        if (mem_q.size() != 0) void'(mem_q.pop_front());
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      mcount  = 0;
      mem_ack = 1'b0;
    end
  end

  task automatic waitIdle();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (resp_q.size() == 0 && mem_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      recordFail("timeout");
      resp_q.delete();
      mem_q.delete();
    end
    @(negedge clk);
  endtask

  // Issue one request (called at a negedge) and queue the hand-computed response.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                               input int ack_after, input logic [31:0] mdata,
                               input logic [31:0] exp_rdata, input logic exp_hit);
    resp_exp_t e;
    mem_exp_t  m;
    bit        uses_mem;
    uses_mem      = wr || !exp_hit;
    ack_after_cfg = ack_after;
    mem_data_cfg  = mdata;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    e.rdata      = exp_rdata;
    e.hit        = exp_hit;
    e.accept_cyc = cyc;
    e.lat        = uses_mem ? 2 + ack_after : 2;
    resp_q.push_back(e);
    if (uses_mem) begin
      m.wr    = wr;
      m.addr  = addr;
      m.wdata = wdata;
      mem_q.push_back(m);
    end
    req_valid = 1'b0;
    waitIdle();
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
    checkOutput("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
`ifdef ASSOC_CACHE_PERF_CNT_EN
    checkOutput("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    checkOutput("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic read/write sequence");
    applyStimulus(1'b0, 8'h05, 32'h0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 8'h05, 32'h0, 1, 32'h0, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b1, 8'h05, 32'h12345678, 1, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 8'h05, 32'h0, 1, 32'h0, 32'h12345678, 1'b1);
    applyStimulus(1'b1, 8'h77, 32'hCAFEF00D, 2, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 8'h77, 32'h0, 1, 32'h77770000, 32'h77770000, 1'b0);

    $display("[TB] replacement sequence");
    pulseFlush();
    applyStimulus(1'b0, 8'h10, 32'h0, 1, 32'hA0000010, 32'hA0000010, 1'b0);
    applyStimulus(1'b0, 8'h11, 32'h0, 2, 32'hA0000011, 32'hA0000011, 1'b0);
    applyStimulus(1'b0, 8'h12, 32'h0, 1, 32'hA0000012, 32'hA0000012, 1'b0);
    applyStimulus(1'b0, 8'h13, 32'h0, 2, 32'hA0000013, 32'hA0000013, 1'b0);
    applyStimulus(1'b0, 8'h14, 32'h0, 1, 32'hA0000014, 32'hA0000014, 1'b0);
    applyStimulus(1'b0, 8'h15, 32'h0, 1, 32'hA0000015, 32'hA0000015, 1'b0);
    applyStimulus(1'b0, 8'h12, 32'h0, 1, 32'h0, 32'hA0000012, 1'b1);
    applyStimulus(1'b0, 8'h13, 32'h0, 1, 32'h0, 32'hA0000013, 1'b1);
    applyStimulus(1'b0, 8'h10, 32'h0, 1, 32'hB0000010, 32'hB0000010, 1'b0);
    applyStimulus(1'b0, 8'h12, 32'h0, 1, 32'hB0000012, 32'hB0000012, 1'b0);
    applyStimulus(1'b0, 8'h13, 32'h0, 1, 32'hB0000013, 32'hB0000013, 1'b0);
    applyStimulus(1'b0, 8'h15, 32'h0, 1, 32'h0, 32'hA0000015, 1'b1);
    applyStimulus(1'b0, 8'h10, 32'h0, 1, 32'h0, 32'hB0000010, 1'b1);

    $display("[TB] flush priority");
    flush     = 1'b1;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 8'h12;
    #1;
    checkOutput("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    checkOutput("post_flush_idle", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h12, 32'h0, 2, 32'hC0000012, 32'hC0000012, 1'b0);

    $display("[TB] reset during miss");
    ack_after_cfg = 1000;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 8'h33;
    @(posedge clk);
    #1;
    begin
      mem_exp_t m;
      m.wr = 1'b0;
      m.addr = 8'h33;
      m.wdata = '0;
      mem_q.push_back(m);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("miss_mem_req_held", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mem_req_after_rst", {31'd0, mem_req}, 32'd0);
    checkOutput("resp_valid_after_rst", {31'd0, resp_valid}, 32'd0);
`ifdef ASSOC_CACHE_PERF_CNT_EN
    checkOutput("rst2_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    checkOutput("rst2_miss_cnt", {16'd0, miss_cnt}, 32'd0);
`endif
    mem_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", {31'd0, req_ready}, 32'd1);
    applyStimulus(1'b0, 8'h33, 32'h0, 2, 32'h33333333, 32'h33333333, 1'b0);
    applyStimulus(1'b0, 8'h12, 32'h0, 1, 32'hD0000012, 32'hD0000012, 1'b0);
`ifdef ASSOC_CACHE_PERF_CNT_EN
    checkOutput("final_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    checkOutput("final_miss_cnt", {16'd0, miss_cnt}, 32'd2);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
- Parametrised fully-associative cache controller; next generation of the fixed 16-entry tag-compare cache.
- Adds configurable address width, data width and line count, plus per-line valid bits.
- Adds a victim-selection and replacement policy and a write-through policy.
- Talks to the backing instruction/data memory over a req/ack handshake, so one memory model serves any latency.

Parameters:
ADDR_W, 8, request/tag address width in bits (full address is the tag; one word per line)
DATA_W, 32, data word width in bits
LINES, 16, number of cache lines; power of two, 2..64

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
flush  in  1  invalidate all lines; sampled only in IDLE
req_valid  in  1  CPU request present
req_ready  out  1  high only in IDLE with flush low; request accepted when req_valid & req_ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle pulse, response complete
resp_rdata  out  DATA_W  read data; 0 for writes
resp_hit  out  1  1 if lookup hit, qualified by resp_valid
mem_req  out  1  backing-memory request, held until mem_ack
mem_wr  out  1  1 = memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory done; mem_rdata valid in the same cycle for reads
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst_n low at an edge):
  - All valid bits cleared; replacement pointer = 0; state = IDLE.
  - All outputs 0 except req_ready, which is 1 in the first cycle after reset.
  - Tag and data arrays are not cleared.
- States: IDLE, LOOKUP, MISS_RD, WR_THRU, RESP.
- IDLE:
  - flush=1: all valid bits cleared at that edge; stay IDLE; req_ready=0 in that cycle. flush has priority over req_valid.
  - Otherwise, on accept: capture wr, addr and wdata; go to LOOKUP.
- LOOKUP (1 cycle): compare the captured addr with every tag whose valid bit is set. On multiple matches (illegal), the lowest index wins.
  - Read hit: go to RESP with rdata = line data, hit = 1.
  - Read miss: go to MISS_RD.
  - Write hit: update line data at this edge, then go to WR_THRU with hit = 1.
  - Write miss: no allocate; go to WR_THRU with hit = 0.
- MISS_RD: mem_req=1, mem_wr=0, mem_addr = captured addr, all held stable until mem_ack=1.
  - At the ack edge, fill the victim: tag = addr, data = mem_rdata, valid = 1.
  - Then go to RESP with rdata = mem_rdata, hit = 0.
- Victim selection:
  - Lowest-index invalid line if any exist; the pointer is unchanged.
  - Otherwise the line at the pointer; the pointer then increments modulo LINES, wrapping LINES-1 to 0.
- WR_THRU: mem_req=1, mem_wr=1, mem_addr and mem_wdata = captured values, held until mem_ack. On the ack edge go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request can be accepted in the following cycle.
- Latency from accept edge to resp_valid cycle:
  - Read hit: 2 cycles.
  - Read miss or write: 2 + n cycles, where n is the number of cycles mem_req is high before and including the ack cycle. n = 1 when mem_ack is already high in the first mem_req cycle.
- mem_ack is ignored outside MISS_RD and WR_THRU.
- Reset mid-miss or mid-write: operation abandoned, no fill, no resp_valid; mem_req low from the next cycle.
- resp_rdata and resp_hit hold their last value when resp_valid=0.

Optional Feature:
- Macro: ASSOC_CACHE_PERF_CNT_EN.
- When defined, adds outputs hit_cnt and miss_cnt, both 16 bits.
  - Each increments by 1 on the LOOKUP cycle of a hit or a miss respectively, reads and writes both counted.
  - Both saturate at 16'hFFFF; both clear on reset; flush does not clear them.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then read addr 8'h05; memory acks on its 3rd mem_req cycle with 32'hDEAD_BEEF -> mem_req for 3 cycles, resp_valid 5 cycles after accept, rdata=32'hDEADBEEF, hit=0.
- Read 8'h05 again -> no mem_req, resp_valid 2 cycles after accept, rdata=32'hDEADBEEF, hit=1.
- Write 8'h05 with 32'h1234_5678, single-cycle ack -> mem_wr=1, mem_wdata=32'h12345678, hit=1. Then read 8'h05 -> hit=1, rdata=32'h12345678 with no mem_req.
- LINES=4: read misses to 8'h10, 11, 12, 13 fill lines 0-3. Miss on 8'h14 replaces line 0; miss on 8'h15 replaces line 1. A following read of 8'h10 misses, 8'h12 hits.
- Pulse flush in IDLE, then read 8'h12 -> miss, mem_req=1; req_ready=0 in the flush cycle.
- Assert rst_n=0 during MISS_RD -> mem_req=0 next cycle, no resp_valid. After reset, read of the same address misses. With ASSOC_CACHE_PERF_CNT_EN: hit_cnt=0 and miss_cnt=0 after reset.
